mem_credit_rx: RTL and testbench
================================

MEM_CREDIT_RX -- requirements
Module: mem_credit_rx

Interface
REQ-001 Parameter DEPTH, default 64 (equal to MAXMEMCREDIT), gives the receive buffer entries and the credits the sender holds after reset.
REQ-002 Parameter DWIDTH, default 64, gives the memory network flit payload width in bits.
REQ-003 gclk  in  1  is the single clock; all state changes on its rising edge.
REQ-004 rst  in  1  is the reset; asynchronous, active-high.
REQ-005 in_valid  in  1  means the network delivers one flit this cycle; the sender asserts it only while holding a credit.
REQ-006 in_data  in  DWIDTH  is the flit payload.
REQ-007 out_valid  out  1  means the buffer head is presented to the consumer.
REQ-008 out_data  out  DWIDTH  is the buffer head payload.
REQ-009 out_ready  in  1  means the consumer accepts the head this cycle.
REQ-010 credit_ret  out  1  is a one-cycle pulse returning exactly one credit to the sender.
REQ-011 count  out  log2x(DEPTH)+1  is the current occupancy, 0..DEPTH.
REQ-012 overflow  out  1  is a sticky protocol error: a flit arrived while the buffer was full.
REQ-013 parity_err  out  1  is a sticky error: stored-entry parity mismatch at dequeue (see REQ-029).

Function
REQ-014 The buffer SHALL be a FIFO of DEPTH entries with write pointer, read pointer and occupancy counter; pointers wrap from DEPTH-1 to 0.
REQ-015 Enqueue SHALL occur when in_valid=1 and count<DEPTH; in_data is written at the write pointer, which increments.
REQ-016 Dequeue SHALL occur when out_valid=1 and out_ready=1; the read pointer increments.
REQ-017 out_valid SHALL equal (count!=0), registered; a flit enqueued into an empty buffer in cycle N is visible on out_valid/out_data in cycle N+1.
REQ-018 out_data SHALL remain stable while out_valid=1 and out_ready=0.
REQ-019 Simultaneous enqueue and dequeue SHALL leave count unchanged, including at count=DEPTH-1 and at count=1.
REQ-020 When count=DEPTH and in_valid=1, the flit SHALL be dropped and overflow set, even if a dequeue occurs in the same cycle.
REQ-021 When count=0, out_ready SHALL be ignored and no credit returned.
REQ-022 credit_ret SHALL pulse high in cycle N+1 for every dequeue in cycle N; at most one pulse per cycle, never merged.
REQ-023 Credits returned since reset SHALL never exceed flits accepted since reset.
REQ-024 No credit pulses SHALL be issued after reset; the sender starts with DEPTH credits implicitly.

Reset
REQ-025 On rst=1, asynchronously: pointers=0, count=0, out_valid=0, credit_ret=0, overflow=0, parity_err=0; out_data is don't-care.
REQ-026 Buffer storage SHALL NOT require reset (LUTram/BRAM mappable).
REQ-027 Reset asserted mid-operation SHALL discard all buffered flits and any pending credit pulse; the sender is reset in the same domain.
REQ-028 The first enqueue SHALL be accepted in the first rising edge after rst deasserts.

Configuration
REQ-029 With macro MEMCREDIT_PARITY_EN defined, each entry SHALL store one extra even-parity bit over in_data; on dequeue a mismatch sets parity_err (sticky until reset), and the flit is still delivered and its credit returned.
REQ-030 Without MEMCREDIT_PARITY_EN, no parity bit SHALL be stored and parity_err SHALL be tied to 0.

Verification
REQ-031 Reset, then in_valid one cycle with in_data=64'hDEAD_BEEF_0000_0001, out_ready=0 -> next cycle out_valid=1, out_data matches, count=1, credit_ret=0.
REQ-032 Fill 64 flits with out_ready=0, then 65th in_valid -> count=64, overflow=1, 65th flit never appears at output.
REQ-033 Count=64, out_ready=1 for 64 cycles -> 64 in-order flits, 64 single-cycle credit_ret pulses each one cycle after its dequeue, count=0, out_valid=0.
REQ-034 Count=63 with in_valid=1 and dequeue on same cycle for 200 cycles -> count stays 63, pointers wrap, data order preserved, no overflow.
REQ-035 Count=10, assert rst mid-dequeue for one cycle -> count=0, out_valid=0, no credit_ret in the following cycle.
REQ-036 With MEMCREDIT_PARITY_EN, force-flip one stored bit of entry 0 then dequeue -> parity_err=1 and stays 1, credit_ret still pulses; without the macro, parity_err=0.

Source files
------------

// File: rtl/mem_credit_rx.sv
// Credit-based receive buffer for memory-network flits: FIFO of DEPTH entries; one credit is returned per dequeue.
// Optional stored even parity per entry when MEMCREDIT_PARITY_EN is defined.
module mem_credit_rx #(
  parameter int DEPTH  = 64,
  parameter int DWIDTH = 64
) (
  input  logic                     gclk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [DWIDTH-1:0]        in_data,
  output logic                     out_valid,
  output logic [DWIDTH-1:0]        out_data,
  input  logic                     out_ready,
  output logic                     credit_ret,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     parity_err
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
`ifdef MEMCREDIT_PARITY_EN
  localparam int EW = DWIDTH + 1;
`else
  localparam int EW = DWIDTH;
`endif

  logic [EW-1:0] mem_q [DEPTH];
  logic [EW-1:0] wdata, head;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          out_valid_q, credit_q, overflow_q;
  logic          full, enq, deq;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // A flit arriving while full is dropped even if the head leaves this cycle.
  assign full = (count_q == CW'(DEPTH));
  assign enq  = in_valid & ~full;
  assign deq  = out_valid_q & out_ready;

  always_comb begin
    wr_ptr_d = enq ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = deq ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    case ({enq, deq})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

`ifdef MEMCREDIT_PARITY_EN
  assign wdata = {^in_data, in_data};
`else
  assign wdata = in_data;
`endif

  // Storage has no reset so it maps onto distributed or block RAM.
  always_ff @(posedge gclk) begin
    if (enq) mem_q[wr_ptr_q] <= wdata;
  end

  assign head = mem_q[rd_ptr_q];

  always_ff @(posedge gclk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      credit_q    <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_valid_q <= (count_d != '0);
      credit_q    <= deq;
      overflow_q  <= overflow_q | (in_valid & full);
    end
  end

`ifdef MEMCREDIT_PARITY_EN
  logic parity_err_q;
  always_ff @(posedge gclk or posedge rst) begin
    if (rst)                parity_err_q <= 1'b0;
    else if (deq && ^head)  parity_err_q <= 1'b1;
  end
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

  assign out_valid  = out_valid_q;
  assign out_data   = head[DWIDTH-1:0];
  assign credit_ret = credit_q;
  assign count      = count_q;
  assign overflow   = overflow_q;
endmodule

// File: tb/tb_mem_credit_rx.sv
// Directed bench for mem_credit_rx (DEPTH=64, DWIDTH=64); expected data comes from a queue of flits sent.
module tb_mem_credit_rx;
  logic        gclk = 1'b0;
  logic        rst, in_valid, out_ready;
  logic [63:0] in_data, out_data;
  logic        out_valid, credit_ret, overflow, parity_err;
  logic [6:0]  count;
  logic [63:0] q[$];
  int          n_chk = 0, n_err = 0;

  mem_credit_rx #(.DEPTH(64), .DWIDTH(64)) dut (
    .gclk(gclk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .credit_ret(credit_ret), .count(count), .overflow(overflow), .parity_err(parity_err)
  );

  always #5 gclk = ~gclk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge gclk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    step(); step();
    rst = 1'b0;
    q.delete();
  endtask

  task automatic push(input logic [63:0] d);
    in_valid = 1'b1; in_data = d; q.push_back(d);
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    step();
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_credit", 64'(credit_ret), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    chk("rst_par", 64'(parity_err), 64'd0);
    q.delete();

    // First flit on the first edge after reset release
    rst = 1'b0;
    push(64'hDEAD_BEEF_0000_0001);
    chk("first_valid", 64'(out_valid), 64'd1);
    chk("first_data", out_data, 64'hDEAD_BEEF_0000_0001);
    chk("first_count", 64'(count), 64'd1);
    chk("first_credit", 64'(credit_ret), 64'd0);

    for (int i = 1; i < 64; i++) push(64'(i));
    chk("fill_ovf0", 64'(overflow), 64'd0);
    in_valid = 1'b1; in_data = 64'hBAD0_BAD0_BAD0_BAD0;
    step();
    in_valid = 1'b0;
    chk("full_count", 64'(count), 64'd64);
    chk("full_ovf", 64'(overflow), 64'd1);
    chk("full_head", out_data, 64'hDEAD_BEEF_0000_0001);

    // Drain: in-order data, one credit pulse the cycle after each dequeue
    out_ready = 1'b1;
    for (int k = 0; k < 64; k++) begin
      chk("drain_valid", 64'(out_valid), 64'd1);
      chk("drain_data", out_data, q.pop_front());
      step();
      chk("drain_credit", 64'(credit_ret), 64'd1);
    end
    chk("drain_count", 64'(count), 64'd0);
    chk("drain_valid_end", 64'(out_valid), 64'd0);
    step();
    chk("empty_ready_credit", 64'(credit_ret), 64'd0);
    out_ready = 1'b0;

    // Steady state at DEPTH-1 with simultaneous enq/deq; pointers wrap
    do_reset();
    for (int i = 0; i < 63; i++) push(64'(1000 + i));
    chk("c63_count", 64'(count), 64'd63);
    in_valid = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 200; k++) begin
      in_data = 64'(2000 + k);
      q.push_back(in_data);
      chk("c63_data", out_data, q.pop_front());
      step();
      chk("c63_credit", 64'(credit_ret), 64'd1);
    end
    in_valid = 1'b0; out_ready = 1'b0;
    chk("c63_count_end", 64'(count), 64'd63);
    chk("c63_ovf", 64'(overflow), 64'd0);
    step();
    chk("c63_credit_end", 64'(credit_ret), 64'd0);

    // Simultaneous enq/deq at count=1
    do_reset();
    push(64'd77);
    in_valid = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_data = 64'(80 + k);
      q.push_back(in_data);
      chk("c1_data", out_data, q.pop_front());
      step();
      chk("c1_count", 64'(count), 64'd1);
    end
    in_valid = 1'b0; out_ready = 1'b0;

    // Reset mid-dequeue drops buffered flits and the pending credit
    do_reset();
    for (int i = 0; i < 10; i++) push(64'(300 + i));
    out_ready = 1'b1;
    step();
    chk("mid_count", 64'(count), 64'd9);
    chk("mid_credit", 64'(credit_ret), 64'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_count", 64'(count), 64'd0);
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_credit", 64'(credit_ret), 64'd0);
    step();
    rst = 1'b0;
    step();
    chk("post_rst_credit", 64'(credit_ret), 64'd0);
    chk("post_rst_count", 64'(count), 64'd0);
    chk("post_rst_valid", 64'(out_valid), 64'd0);
    out_ready = 1'b0;

`ifdef MEMCREDIT_PARITY_EN
    do_reset();
    push(64'd5);
    push(64'd6);
    dut.mem_q[0][3] = ~dut.mem_q[0][3];
    out_ready = 1'b1;
    step();
    chk("par_err", 64'(parity_err), 64'd1);
    chk("par_credit", 64'(credit_ret), 64'd1);
    step();
    out_ready = 1'b0;
    step();
    chk("par_sticky", 64'(parity_err), 64'd1);
    chk("par_count", 64'(count), 64'd0);
`else
    chk("par_tied0", 64'(parity_err), 64'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
